apb4_decoder_n: RTL
===================

# apb4_decoder_n

Parametrised APB4 completer-side decoder that fans one requester port out to `NUM_SLAVES` completers. It selects the completer from an address index field and latches the selection for the whole transfer. Unmapped addresses get a default-slave error response, and an optional watchdog terminates stalled transfers with an error. It sits between the APB4 bridge/master and the peripheral completers, alongside the existing 2-slave decoder.

## Interface
- `DATA_WIDTH`, 32, PRDATA width.
- `ADDR_WIDTH`, 32, PADDR width.
- `NUM_SLAVES`, 4, number of completers (2..16).
- `IDX_LSB`, 12, lowest PADDR bit of the completer index field.
- `IDX_W`, 2, index field width; index = PADDR[IDX_LSB+IDX_W-1:IDX_LSB].
- `TIMEOUT_CYCLES`, 16, maximum ACCESS cycles per transfer (>=2).

Ports:
- `PCLK` in 1: sole clock; all state updates on the rising edge.
- `PRESET` in 1: synchronous, active-high reset.
- `PSEL` in 1: requester select.
- `PENABLE` in 1: requester enable.
- `PADDR` in ADDR_WIDTH: requester address.
- `PSEL_S` out NUM_SLAVES: one-hot completer selects.
- `PRDATA_S` in NUM_SLAVES*DATA_WIDTH: completer read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `PREADY_S` in NUM_SLAVES: completer ready signals.
- `PSLVERR_S` in NUM_SLAVES: completer error signals.
- `PRDATA` out DATA_WIDTH: read data to requester.
- `PREADY` out 1: ready to requester.
- `PSLVERR` out 1: error to requester.
- `ERR_CNT` out 8: saturating count of decoder-generated errors.

## Operation
- State machine has two states: IDLE and ACCESS.
- Reset:
  - State goes to IDLE; `sel_q`, `hit_q`, the timeout counter and `ERR_CNT` clear to 0.
  - Combinational outputs settle as `PSEL_S`=0, `PRDATA`=0, `PREADY`=0, `PSLVERR`=0.
- Decode:
  - idx = index field of PADDR.
  - hit = (idx < NUM_SLAVES).
- IDLE, with PSEL=1 and PENABLE=0 (SETUP):
  - `PSEL_S[idx]` = hit, combinationally.
  - Registers update: `sel_q`<=idx, `hit_q`<=hit, tcnt<=0, state<=ACCESS.
- IDLE, with PSEL=1 and PENABLE=1 (protocol violation): ignored. Outputs stay 0 and the state stays IDLE.
- ACCESS, with PSEL=1:
  - `PSEL_S[sel_q]` = hit_q. PADDR changes during ACCESS are ignored.
  - If hit_q=0 (default slave): `PREADY`=1, `PSLVERR`=1, `PRDATA`=0. `ERR_CNT` increments.
  - If hit_q=1:
    - `PREADY` = PREADY_S[sel_q].
    - `PSLVERR` = PSLVERR_S[sel_q] & PREADY_S[sel_q].
    - `PRDATA` = slice sel_q of PRDATA_S.
  - If PREADY_S[sel_q]=0, tcnt increments.
  - Timeout: when tcnt == TIMEOUT_CYCLES-1 and PREADY_S[sel_q]=0:
    - Outputs are forced to `PREADY`=1, `PSLVERR`=1, `PRDATA`=0.
    - `ERR_CNT` increments.
  - When `PREADY`=1, state<=IDLE.
- ACCESS with PSEL=0 (requester abort): state<=IDLE and `PSEL_S`=0. No error is counted.
- `ERR_CNT` saturates at 255. Completer-reported PSLVERR is passed through but not counted.
- Outputs are always 0 whenever the decoder is not in ACCESS with PSEL=1.

## Timing
- Completer select asserts with zero latency, in the same cycle as the requester SETUP phase.
- Return path (PRDATA/PREADY/PSLVERR) is purely combinational from the completer inputs in ACCESS. There are no extra wait states.
- Unmapped transfer: 2 cycles total (SETUP, then ACCESS with PREADY=1).
- Worst case with timeout: 1 SETUP cycle plus TIMEOUT_CYCLES ACCESS cycles. PREADY rises in ACCESS cycle TIMEOUT_CYCLES.
- Completer ready in the same cycle as the timeout: the completer's response wins. There is no timeout error and no count.
- Back-to-back transfers: a new SETUP is accepted in the cycle after PREADY=1.
- Reset asserted mid-ACCESS: the next edge returns the block to IDLE, outputs drop to 0, and `ERR_CNT` clears.
- `ERR_CNT` updates on the edge that ends the erroring ACCESS cycle.

## Configuration
- `APB4_DEC_TIMEOUT_EN`:
  - Defined: the timeout counter and timeout termination are built as described above.
  - Undefined: no counter is instantiated and `TIMEOUT_CYCLES` is ignored. ACCESS waits indefinitely for PREADY_S[sel_q], and `ERR_CNT` counts decode errors only.

## Test plan
- Reset then idle: hold PRESET=1 for 2 cycles -> all outputs 0 and `ERR_CNT`=0. With PSEL=0, PSEL_S stays 0.
- Mapped read: PADDR=0x0000_2000 (idx 2), PREADY_S[2]=1, PRDATA_S slice 2=0xCAFE_F00D -> PSEL_S=4'b0100 in SETUP. PRDATA=0xCAFE_F00D, PREADY=1 and PSLVERR=0 in the first ACCESS cycle.
- Unmapped: NUM_SLAVES=3, PADDR=0x3000 -> PSEL_S=0. The first ACCESS cycle gives PREADY=1, PSLVERR=1, PRDATA=0, and `ERR_CNT` goes 0->1.
- Timeout (macro defined, TIMEOUT_CYCLES=16): slave 1 holds PREADY_S=0 -> PREADY=0 for ACCESS cycles 1..15, then PREADY=1 and PSLVERR=1 in cycle 16, and `ERR_CNT` increments. A repeat where the slave readies in cycle 16 -> its data is returned, PSLVERR=0, and there is no count.
- Wait states and pass-through error: slave 0 inserts 3 waits, then PREADY_S=1 and PSLVERR_S=1 -> PREADY=1 and PSLVERR=1 in ACCESS cycle 4. `ERR_CNT` is unchanged.
- Abort and saturation: drop PSEL mid-ACCESS -> PSEL_S=0 the next cycle and the block is ready for a new SETUP. Then 260 unmapped transfers -> `ERR_CNT`=255.

Source files
------------

// File: rtl/apb4_decoder_n.sv
// APB4 completer-side decoder: one requester fanned out to NUM_SLAVES completers,
// with default-slave errors and an optional stall watchdog (APB4_DEC_TIMEOUT_EN).
module apb4_decoder_n #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int IDX_LSB        = 12,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic                             PSEL,
    input  logic                             PENABLE,
    input  logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [NUM_SLAVES-1:0]            PSEL_S,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA_S,
    input  logic [NUM_SLAVES-1:0]            PREADY_S,
    input  logic [NUM_SLAVES-1:0]            PSLVERR_S,
    output logic [DATA_WIDTH-1:0]            PRDATA,
    output logic                             PREADY,
    output logic                             PSLVERR,
    output logic [7:0]                       ERR_CNT
);

    // state  | meaning
    // IDLE   | waiting for a SETUP phase (PSEL=1, PENABLE=0)
    // ACCESS | selection latched, waiting for completer ready, error or abort
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic             hit_q, hit_d;
    logic [7:0]       err_q, err_d;

    logic [IDX_W-1:0]      idx;
    logic [31:0]           idx_ext, sel_ext;
    logic                  hit, setup, active, timeout, err_evt;
    logic [DATA_WIDTH-1:0] s_rdata;
    logic                  s_ready, s_err;
    logic                  unused_paddr;

    assign idx          = PADDR[IDX_LSB +: IDX_W];
    assign idx_ext      = 32'(idx);
    assign sel_ext      = 32'(sel_q);
    assign hit          = (idx_ext < 32'(NUM_SLAVES));
    assign setup        = (state_q == S_IDLE) && PSEL && !PENABLE;
    assign active       = (state_q == S_ACCESS) && PSEL;
    assign unused_paddr = ^PADDR;

    always_comb begin
        s_rdata = '0;
        s_ready = 1'b0;
        s_err   = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_ext == 32'(i)) begin
                s_rdata = PRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                s_ready = PREADY_S[i];
                s_err   = PSLVERR_S[i];
            end
        end
    end

`ifdef APB4_DEC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tcnt_q, tcnt_d;

    // A completer that readies in the terminal cycle still wins over the watchdog.
    assign timeout = active && hit_q && !s_ready && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tcnt_d = tcnt_q;
        if (setup)
            tcnt_d = '0;
        else if (active && !s_ready)
            tcnt_d = tcnt_q + 1'b1;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET)
            tcnt_q <= '0;
        else
            tcnt_q <= tcnt_d;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_comb begin
        PSEL_S  = '0;
        PRDATA  = '0;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        if (setup) begin
            for (int i = 0; i < NUM_SLAVES; i++)
                PSEL_S[i] = hit && (idx_ext == 32'(i));
        end else if (active) begin
            for (int i = 0; i < NUM_SLAVES; i++)
                PSEL_S[i] = hit_q && (sel_ext == 32'(i));
            if (!hit_q || timeout) begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
            end else begin
                PREADY  = s_ready;
                PSLVERR = s_err && s_ready;
                PRDATA  = s_rdata;
            end
        end
    end

    assign err_evt = active && (!hit_q || timeout);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hit_d   = hit_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (setup) begin
                    state_d = S_ACCESS;
                    sel_d   = idx;
                    hit_d   = hit;
                end
            end
            default: begin
                if (!PSEL || PREADY)
                    state_d = S_IDLE;
            end
        endcase
        if (err_evt && (err_q != 8'hFF))
            err_d = err_q + 8'd1;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            hit_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            hit_q   <= hit_d;
            err_q   <= err_d;
        end
    end

    assign ERR_CNT = err_q;

endmodule
